// File: rtl/tinyrisc_pkg.sv
// Shared encodings for the tinyrisc RV32I core: opcodes, funct fields,
// zero constants, write-enable levels and small field-legality helpers.
package tinyrisc_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    // ALU funct3
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    // Load / store widths
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Branch funct3 codes with no defined instruction
    localparam logic [2:0] F3_BR_RSV0 = 3'b010;
    localparam logic [2:0] F3_BR_RSV1 = 3'b011;

    // JALR and SYSTEM
    localparam logic [2:0] F3_JALR    = 3'b000;
    localparam logic [2:0] F3_PRIV    = 3'b000;
    localparam logic [2:0] F3_CSR_RSV = 3'b100;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [4:0]  ZeroReg      = 5'd0;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;

    // Register-register ops: funct7 0100000 only selects SUB and SRA.
    function automatic logic op_funct_ok(input logic [2:0] f3, input logic [6:0] f7);
        return (f7 == F7_BASE) ||
               ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA)));
    endfunction

    // Immediate shifts reuse the upper immediate bits as funct7.
    function automatic logic shift_imm_ok(input logic [2:0] f3, input logic [6:0] f7);
        if (f3 == F3_SLL)     return f7 == F7_BASE;
        if (f3 == F3_SRL_SRA) return (f7 == F7_BASE) || (f7 == F7_ALT);
        return 1'b1;
    endfunction

endpackage

// File: rtl/id_decode.sv
// Pure combinational RV32I decoder: fields, immediates, operand selection,
// register-use flags and illegal-instruction detection.
module id_decode
    import tinyrisc_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int RADDR_W    = 5,
    parameter bit CSR_EN     = 1'b1,
    parameter int CSR_ADDR_W = 32
) (
    input  logic [31:0]          inst,
    input  logic [XLEN-1:0]      inst_addr,
    input  logic [XLEN-1:0]      reg1_rdata,
    input  logic [XLEN-1:0]      reg2_rdata,
    input  logic [XLEN-1:0]      csr_rdata,
    output logic [RADDR_W-1:0]   rs1_addr,
    output logic [RADDR_W-1:0]   rs2_addr,
    output logic                 rs1_used,
    output logic                 rs2_used,
    output logic [CSR_ADDR_W-1:0] csr_addr,
    output logic [XLEN-1:0]      csr_data,
    output logic [XLEN-1:0]      op1,
    output logic [XLEN-1:0]      op2,
    output logic [XLEN-1:0]      op1_jump,
    output logic [XLEN-1:0]      op2_jump,
    output logic                 regw_enable,
    output logic [RADDR_W-1:0]   regw_addr,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 csrw_enable,
    output logic                 illegal
);

    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] zimm;
    logic            writes_rd;
    logic            csr_sel;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign f3     = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign f7     = inst[31:25];

    assign imm_i = XLEN'($signed(inst[31:20]));
    assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
    assign imm_u = XLEN'($signed({inst[31:12], 12'h000}));
    assign zimm  = XLEN'(rs1);

    // Classify the opcode and select operands; anything unmatched is illegal.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave a signal unassigned and infer a latch.
        rs1_used    = 1'b0;
        rs2_used    = 1'b0;
        writes_rd   = 1'b0;
        csr_sel     = 1'b0;
        op1         = '0;
        op2         = '0;
        op1_jump    = '0;
        op2_jump    = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        csrw_enable = WriteDisable;
        illegal     = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                if (shift_imm_ok(f3, f7)) begin
                    rs1_used  = 1'b1;
                    writes_rd = 1'b1;
                    op1       = reg1_rdata;
                    op2       = imm_i;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OP: begin
                if (op_funct_ok(f3, f7)) begin
                    rs1_used  = 1'b1;
                    rs2_used  = 1'b1;
                    writes_rd = 1'b1;
                    op1       = reg1_rdata;
                    op2       = reg2_rdata;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_LOAD: begin
                if (f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU}) begin
                    rs1_used  = 1'b1;
                    writes_rd = 1'b1;
                    mem_read  = 1'b1;
                    op1       = reg1_rdata;
                    op2       = imm_i;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_STORE: begin
                if (f3 inside {F3_SB, F3_SH, F3_SW}) begin
                    rs1_used  = 1'b1;
                    rs2_used  = 1'b1;
                    mem_write = 1'b1;
                    op1       = reg1_rdata;
                    op2       = imm_s;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_BRANCH: begin
                if ((f3 != F3_BR_RSV0) && (f3 != F3_BR_RSV1)) begin
                    rs1_used = 1'b1;
                    rs2_used = 1'b1;
                    op1      = reg1_rdata;
                    op2      = reg2_rdata;
                    op1_jump = inst_addr;
                    op2_jump = imm_b;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_JAL: begin
                writes_rd = 1'b1;
                op1       = inst_addr;
                op2       = XLEN'(4);
                op1_jump  = inst_addr;
                op2_jump  = imm_j;
            end
            OPC_JALR: begin
                if (f3 == F3_JALR) begin
                    rs1_used  = 1'b1;
                    writes_rd = 1'b1;
                    op1       = inst_addr;
                    op2       = XLEN'(4);
                    op1_jump  = reg1_rdata;
                    op2_jump  = imm_i;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                writes_rd = 1'b1;
                op2       = imm_u;
            end
            OPC_AUIPC: begin
                writes_rd = 1'b1;
                op1       = inst_addr;
                op2       = imm_u;
            end
            OPC_SYSTEM: begin
                if (CSR_EN && (f3 != F3_PRIV) && (f3 != F3_CSR_RSV)) begin
                    // funct3[2] selects the 5-bit zero-extended immediate form.
                    rs1_used    = !f3[2];
                    writes_rd   = 1'b1;
                    csr_sel     = 1'b1;
                    csrw_enable = WriteEnable;
                    op1         = f3[2] ? zimm : reg1_rdata;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

    // Unused read ports and non-written rd collapse to zero; x0 is never written.
    assign rs1_addr    = rs1_used ? RADDR_W'(rs1) : '0;
    assign rs2_addr    = rs2_used ? RADDR_W'(rs2) : '0;
    assign regw_addr   = writes_rd ? RADDR_W'(rd) : '0;
    assign regw_enable = (writes_rd && (rd != ZeroReg)) ? WriteEnable : WriteDisable;
    assign csr_addr    = csr_sel ? CSR_ADDR_W'(inst[31:20]) : '0;
    assign csr_data    = csr_sel ? csr_rdata : '0;

endmodule

// File: rtl/id_stage_pipe.sv
// Registered decode stage: load-use hazard detection, fetch/ex handshake,
// jump flush and the ID/EX pipeline register.
module id_stage_pipe
    import tinyrisc_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int RADDR_W    = 5,
    parameter bit CSR_EN     = 1'b1,
    parameter int CSR_ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid_i,
    input  logic [31:0]           inst_i,
    input  logic [XLEN-1:0]       inst_addr_i,
    output logic                  id_ready_o,
    output logic [RADDR_W-1:0]    regr1_addr_o,
    output logic [RADDR_W-1:0]    regr2_addr_o,
    input  logic [XLEN-1:0]       reg1_rdata_i,
    input  logic [XLEN-1:0]       reg2_rdata_i,
    output logic [CSR_ADDR_W-1:0] csrr_addr_o,
    input  logic [XLEN-1:0]       csr_rdata_i,
    input  logic                  ex_ready_i,
    input  logic                  ex_jump_flag_i,
    output logic                  id_valid_o,
    output logic [31:0]           inst_o,
    output logic [XLEN-1:0]       inst_addr_o,
    output logic [XLEN-1:0]       op1_o,
    output logic [XLEN-1:0]       op2_o,
    output logic [XLEN-1:0]       op1_jump_o,
    output logic [XLEN-1:0]       op2_jump_o,
    output logic [XLEN-1:0]       reg1_rdata_o,
    output logic [XLEN-1:0]       reg2_rdata_o,
    output logic                  regw_enable_o,
    output logic [RADDR_W-1:0]    regw_addr_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic                  csrw_enable_o,
    output logic [CSR_ADDR_W-1:0] csrw_addr_o,
    output logic [XLEN-1:0]       csrw_data_o,
    output logic                  illegal_o
);

    logic                  dec_rs1_used;
    logic                  dec_rs2_used;
    logic [CSR_ADDR_W-1:0] dec_csr_addr;
    logic [XLEN-1:0]       dec_csr_data;
    logic [XLEN-1:0]       dec_op1;
    logic [XLEN-1:0]       dec_op2;
    logic [XLEN-1:0]       dec_op1_jump;
    logic [XLEN-1:0]       dec_op2_jump;
    logic                  dec_regw_enable;
    logic [RADDR_W-1:0]    dec_regw_addr;
    logic                  dec_mem_read;
    logic                  dec_mem_write;
    logic                  dec_csrw_enable;
    logic                  dec_illegal;
    logic                  load_ok;
    logic                  hazard;

    id_decode #(
        .XLEN       (XLEN),
        .RADDR_W    (RADDR_W),
        .CSR_EN     (CSR_EN),
        .CSR_ADDR_W (CSR_ADDR_W)
    ) u_decode (
        .inst        (inst_i),
        .inst_addr   (inst_addr_i),
        .reg1_rdata  (reg1_rdata_i),
        .reg2_rdata  (reg2_rdata_i),
        .csr_rdata   (csr_rdata_i),
        .rs1_addr    (regr1_addr_o),
        .rs2_addr    (regr2_addr_o),
        .rs1_used    (dec_rs1_used),
        .rs2_used    (dec_rs2_used),
        .csr_addr    (dec_csr_addr),
        .csr_data    (dec_csr_data),
        .op1         (dec_op1),
        .op2         (dec_op2),
        .op1_jump    (dec_op1_jump),
        .op2_jump    (dec_op2_jump),
        .regw_enable (dec_regw_enable),
        .regw_addr   (dec_regw_addr),
        .mem_read    (dec_mem_read),
        .mem_write   (dec_mem_write),
        .csrw_enable (dec_csrw_enable),
        .illegal     (dec_illegal)
    );

    assign csrr_addr_o = dec_csr_addr;

    // A load in ID/EX whose rd feeds the fetched instruction forces one bubble.
    assign load_ok    = !id_valid_o || ex_ready_i;
    assign hazard     = id_valid_o && mem_read_o && (regw_addr_o != RADDR_W'(ZeroReg)) &&
                        ((dec_rs1_used && (regr1_addr_o == regw_addr_o)) ||
                         (dec_rs2_used && (regr2_addr_o == regw_addr_o)));
    assign id_ready_o = ex_jump_flag_i || (load_ok && !hazard);

    // ID/EX register: reset, flush, bubble, capture, drain, else hold.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples
        // the pre-edge values, independent of statement order.
        if (!rst) begin
            // NOTE: the whole register is cleared, not just the valid bit,
            // so downstream sees all-zero fields straight out of reset.
            id_valid_o    <= 1'b0;
            inst_o        <= ZeroWord;
            inst_addr_o   <= '0;
            op1_o         <= '0;
            op2_o         <= '0;
            op1_jump_o    <= '0;
            op2_jump_o    <= '0;
            reg1_rdata_o  <= '0;
            reg2_rdata_o  <= '0;
            regw_enable_o <= WriteDisable;
            regw_addr_o   <= '0;
            mem_read_o    <= 1'b0;
            mem_write_o   <= 1'b0;
            csrw_enable_o <= WriteDisable;
            csrw_addr_o   <= '0;
            csrw_data_o   <= '0;
            illegal_o     <= 1'b0;
        end else if (ex_jump_flag_i) begin
            id_valid_o <= 1'b0;
        end else if (load_ok) begin
            if (hazard) begin
                id_valid_o <= 1'b0;
            end else if (if_valid_i) begin
                id_valid_o    <= 1'b1;
                inst_o        <= inst_i;
                inst_addr_o   <= inst_addr_i;
                op1_o         <= dec_op1;
                op2_o         <= dec_op2;
                op1_jump_o    <= dec_op1_jump;
                op2_jump_o    <= dec_op2_jump;
                reg1_rdata_o  <= reg1_rdata_i;
                reg2_rdata_o  <= reg2_rdata_i;
                regw_enable_o <= dec_regw_enable;
                regw_addr_o   <= dec_regw_addr;
                mem_read_o    <= dec_mem_read;
                mem_write_o   <= dec_mem_write;
                csrw_enable_o <= dec_csrw_enable;
                csrw_addr_o   <= dec_csr_addr;
                csrw_data_o   <= dec_csr_data;
                illegal_o     <= dec_illegal;
            end else begin
                id_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed vectors, literal checks
// and an instruction-level reference model compared on every negedge.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid_i;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic        id_ready_o;
    logic [4:0]  regr1_addr_o;
    logic [4:0]  regr2_addr_o;
    logic [31:0] reg1_rdata_i;
    logic [31:0] reg2_rdata_i;
    logic [31:0] csrr_addr_o;
    logic [31:0] csr_rdata_i;
    logic        ex_ready_i;
    logic        ex_jump_flag_i;
    logic        id_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic [31:0] op1_o;
    logic [31:0] op2_o;
    logic [31:0] op1_jump_o;
    logic [31:0] op2_jump_o;
    logic [31:0] reg1_rdata_o;
    logic [31:0] reg2_rdata_o;
    logic        regw_enable_o;
    logic [4:0]  regw_addr_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic        csrw_enable_o;
    logic [31:0] csrw_addr_o;
    logic [31:0] csrw_data_o;
    logic        illegal_o;

    int checks   = 0;
    int failures = 0;
    bit cmp_on   = 1'b0;

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .clk            (clk),
        .rst            (rst),
        .if_valid_i     (if_valid_i),
        .inst_i         (inst_i),
        .inst_addr_i    (inst_addr_i),
        .id_ready_o     (id_ready_o),
        .regr1_addr_o   (regr1_addr_o),
        .regr2_addr_o   (regr2_addr_o),
        .reg1_rdata_i   (reg1_rdata_i),
        .reg2_rdata_i   (reg2_rdata_i),
        .csrr_addr_o    (csrr_addr_o),
        .csr_rdata_i    (csr_rdata_i),
        .ex_ready_i     (ex_ready_i),
        .ex_jump_flag_i (ex_jump_flag_i),
        .id_valid_o     (id_valid_o),
        .inst_o         (inst_o),
        .inst_addr_o    (inst_addr_o),
        .op1_o          (op1_o),
        .op2_o          (op2_o),
        .op1_jump_o     (op1_jump_o),
        .op2_jump_o     (op2_jump_o),
        .reg1_rdata_o   (reg1_rdata_o),
        .reg2_rdata_o   (reg2_rdata_o),
        .regw_enable_o  (regw_enable_o),
        .regw_addr_o    (regw_addr_o),
        .mem_read_o     (mem_read_o),
        .mem_write_o    (mem_write_o),
        .csrw_enable_o  (csrw_enable_o),
        .csrw_addr_o    (csrw_addr_o),
        .csrw_data_o    (csrw_data_o),
        .illegal_o      (illegal_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  r1a, r2a, wa;
        logic [31:0] csra, cwd, op1, op2, j1, j2;
        logic        we, mr, mw, cwe, ill;
    } dec_t;

    // Instruction meaning straight from the ISA tables.
    function automatic dec_t model_decode(input logic [31:0] ins, pc, a, b, c);
        dec_t d;
        logic [4:0]  rd  = ins[11:7];
        logic [4:0]  rs1 = ins[19:15];
        logic [4:0]  rs2 = ins[24:20];
        logic [2:0]  f3  = ins[14:12];
        logic [6:0]  f7  = ins[31:25];
        logic [31:0] ii  = {{20{ins[31]}}, ins[31:20]};
        logic [31:0] is  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        logic [31:0] ib  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        logic [31:0] ij  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        logic [31:0] iu  = {ins[31:12], 12'h000};
        bit ok = 1'b1, u1 = 1'b0, u2 = 1'b0, wr = 1'b0, csr = 1'b0;
        d = '{default: '0};
        case (ins[6:0])
            7'h13: begin  // addi..srai
                if (f3 == 3'd1) ok = (f7 == 7'h00);
                if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
                u1 = 1; wr = 1; d.op1 = a; d.op2 = ii;
            end
            7'h33: begin  // add..and
                ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                u1 = 1; u2 = 1; wr = 1; d.op1 = a; d.op2 = b;
            end
            7'h03: begin  // lb lh lw lbu lhu
                ok = !(f3 == 3'd3 || f3 >= 3'd6);
                u1 = 1; wr = 1; d.mr = 1; d.op1 = a; d.op2 = ii;
            end
            7'h23: begin  // sb sh sw
                ok = (f3 <= 3'd2);
                u1 = 1; u2 = 1; d.mw = 1; d.op1 = a; d.op2 = is;
            end
            7'h63: begin  // beq bne blt bge bltu bgeu
                ok = !(f3 == 3'd2 || f3 == 3'd3);
                u1 = 1; u2 = 1; d.op1 = a; d.op2 = b; d.j1 = pc; d.j2 = ib;
            end
            7'h6F: begin wr = 1; d.op1 = pc; d.op2 = 4; d.j1 = pc; d.j2 = ij; end
            7'h67: begin
                ok = (f3 == 3'd0);
                u1 = 1; wr = 1; d.op1 = pc; d.op2 = 4; d.j1 = a; d.j2 = ii;
            end
            7'h37: begin wr = 1; d.op2 = iu; end
            7'h17: begin wr = 1; d.op1 = pc; d.op2 = iu; end
            7'h73: begin  // csrrw/s/c and immediate forms
                ok = !(f3 == 3'd0 || f3 == 3'd4);
                wr = 1; csr = 1; d.cwe = 1;
                u1 = (f3 < 3'd4);
                d.op1 = (f3 < 3'd4) ? a : {27'd0, rs1};
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            d = '{default: '0};
            d.ill = 1'b1;
            return d;
        end
        d.r1a  = u1 ? rs1 : 5'd0;
        d.r2a  = u2 ? rs2 : 5'd0;
        d.wa   = wr ? rd : 5'd0;
        d.we   = wr && (rd != 5'd0);
        d.csra = csr ? {20'd0, ins[31:20]} : 32'd0;
        d.cwd  = csr ? c : 32'd0;
        return d;
    endfunction

    dec_t        cur;
    dec_t        m_reg;
    logic        m_valid;
    logic [31:0] m_inst, m_pc, m_rd1, m_rd2;
    logic        m_hazard, m_load_ok, m_ready;

    always_comb cur = model_decode(inst_i, inst_addr_i, reg1_rdata_i, reg2_rdata_i, csr_rdata_i);

    // Load-use: the fetched instruction reads the rd of a load sitting in ID/EX.
    always_comb begin
        m_load_ok = !m_valid || ex_ready_i;
        m_hazard  = m_valid && m_reg.mr && (m_reg.wa != 5'd0) &&
                    ((cur.r1a != 5'd0 && cur.r1a == m_reg.wa) ||
                     (cur.r2a != 5'd0 && cur.r2a == m_reg.wa));
        m_ready   = ex_jump_flag_i || (m_load_ok && !m_hazard);
    end

    // Expected ID/EX contents after each edge.
    always @(posedge clk) begin
        if (!rst) begin
            m_valid <= 1'b0;
            m_reg   <= '{default: '0};
            m_inst  <= '0;
            m_pc    <= '0;
            m_rd1   <= '0;
            m_rd2   <= '0;
        end else if (ex_jump_flag_i) begin
            m_valid <= 1'b0;
        end else if (m_load_ok && m_hazard) begin
            m_valid <= 1'b0;
        end else if (m_load_ok && if_valid_i) begin
            m_valid <= 1'b1;
            m_reg   <= cur;
            m_inst  <= inst_i;
            m_pc    <= inst_addr_i;
            m_rd1   <= reg1_rdata_i;
            m_rd2   <= reg2_rdata_i;
        end else if (m_load_ok) begin
            m_valid <= 1'b0;
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            check("id_ready",    id_ready_o,    m_ready);
            check("regr1_addr",  regr1_addr_o,  cur.r1a);
            check("regr2_addr",  regr2_addr_o,  cur.r2a);
            check("csrr_addr",   csrr_addr_o,   cur.csra);
            check("id_valid",    id_valid_o,    m_valid);
            check("inst",        inst_o,        m_inst);
            check("inst_addr",   inst_addr_o,   m_pc);
            check("op1",         op1_o,         m_reg.op1);
            check("op2",         op2_o,         m_reg.op2);
            check("op1_jump",    op1_jump_o,    m_reg.j1);
            check("op2_jump",    op2_jump_o,    m_reg.j2);
            check("reg1_rdata",  reg1_rdata_o,  m_rd1);
            check("reg2_rdata",  reg2_rdata_o,  m_rd2);
            check("regw_enable", regw_enable_o, m_reg.we);
            check("regw_addr",   regw_addr_o,   m_reg.wa);
            check("mem_read",    mem_read_o,    m_reg.mr);
            check("mem_write",   mem_write_o,   m_reg.mw);
            check("csrw_enable", csrw_enable_o, m_reg.cwe);
            check("csrw_addr",   csrw_addr_o,   m_reg.csra);
            check("csrw_data",   csrw_data_o,   m_reg.cwd);
            check("illegal",     illegal_o,     m_reg.ill);
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic [31:0] ins, pc, a, b, c;
    } vec_t;

    vec_t tbl [13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic v, input logic [31:0] ins, pc, a, b, c);
        if_valid_i   = v;
        inst_i       = ins;
        inst_addr_i  = pc;
        reg1_rdata_i = a;
        reg2_rdata_i = b;
        csr_rdata_i  = c;
    endtask

    initial begin
        bit accepted;
        rst = 1'b0; ex_ready_i = 1'b1; ex_jump_flag_i = 1'b0;
        present(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        cmp_on = 1'b1;
        tick();
        check("lit_rst_valid", id_valid_o, 1'b0);
        check("lit_rst_op1", op1_o, 32'h0);
        check("lit_rst_wa", regw_addr_o, 5'd0);
        check("lit_rst_ready", id_ready_o, 1'b1);
        rst = 1'b1;

        // addi x1,x2,-1
        present(1'b1, 32'hFFF10093, 32'h0, 32'd5, 32'd0, 32'd0);
        #1 check("lit_addi_rs1", regr1_addr_o, 5'd2);
        tick();
        check("lit_addi_valid", id_valid_o, 1'b1);
        check("lit_addi_op1", op1_o, 32'd5);
        check("lit_addi_op2", op2_o, 32'hFFFFFFFF);
        check("lit_addi_wa", regw_addr_o, 5'd1);
        check("lit_addi_we", regw_enable_o, 1'b1);

        // lw x5,0(x1) then add x6,x5,x5: one bubble
        present(1'b1, 32'h0000A283, 32'h4, 32'h200, 32'h0, 32'h0);
        tick();
        check("lit_lw_mr", mem_read_o, 1'b1);
        present(1'b1, 32'h00528333, 32'h8, 32'd7, 32'd7, 32'h0);
        #1 check("lit_lu_ready", id_ready_o, 1'b0);
        tick();
        check("lit_lu_bubble", id_valid_o, 1'b0);
        check("lit_lu_ready2", id_ready_o, 1'b1);
        tick();
        check("lit_add_valid", id_valid_o, 1'b1);
        check("lit_add_wa", regw_addr_o, 5'd6);
        check("lit_add_op1", op1_o, 32'd7);

        // beq x1,x2,+8 at 0x100
        present(1'b1, 32'h00208463, 32'h100, 32'd3, 32'd3, 32'h0);
        tick();
        check("lit_beq_j1", op1_jump_o, 32'h100);
        check("lit_beq_j2", op2_jump_o, 32'd8);
        check("lit_beq_we", regw_enable_o, 1'b0);

        // ex stall for three cycles with a flush in the second
        ex_ready_i = 1'b0;
        present(1'b1, 32'h00700193, 32'h104, 32'h0, 32'h0, 32'h0);
        #1 check("lit_stall_ready", id_ready_o, 1'b0);
        tick();
        check("lit_stall_hold", op1_jump_o, 32'h100);
        check("lit_stall_valid", id_valid_o, 1'b1);
        ex_jump_flag_i = 1'b1;
        #1 check("lit_flush_ready", id_ready_o, 1'b1);
        tick();
        check("lit_flush_valid", id_valid_o, 1'b0);
        ex_jump_flag_i = 1'b0;
        tick();
        check("lit_refill_valid", id_valid_o, 1'b1);
        check("lit_refill_op2", op2_o, 32'd7);
        ex_ready_i = 1'b1;

        // illegal word, then addi to x0
        present(1'b1, 32'hFFFFFFFF, 32'h108, 32'd1, 32'd2, 32'h0);
        #1 check("lit_ill_rs1", regr1_addr_o, 5'd0);
        tick();
        check("lit_ill_flag", illegal_o, 1'b1);
        check("lit_ill_we", regw_enable_o, 1'b0);
        check("lit_ill_valid", id_valid_o, 1'b1);
        present(1'b1, 32'h00108013, 32'h10C, 32'd9, 32'd0, 32'h0);
        tick();
        check("lit_x0_we", regw_enable_o, 1'b0);
        check("lit_x0_ill", illegal_o, 1'b0);

        // fetch gap drains the register
        present(1'b0, 32'h00108013, 32'h110, 32'd9, 32'd0, 32'h0);
        tick();
        check("lit_gap_valid", id_valid_o, 1'b0);

        // lui, jal, csrrwi
        present(1'b1, 32'h123452B7, 32'h114, 32'h0, 32'h0, 32'h0);
        tick();
        check("lit_lui_op1", op1_o, 32'h0);
        check("lit_lui_op2", op2_o, 32'h12345000);
        present(1'b1, 32'h008000EF, 32'h118, 32'h0, 32'h0, 32'h0);
        tick();
        check("lit_jal_op1", op1_o, 32'h118);
        check("lit_jal_op2", op2_o, 32'd4);
        check("lit_jal_j2", op2_jump_o, 32'd8);
        present(1'b1, 32'h3002D3F3, 32'h11C, 32'hDEAD, 32'h0, 32'h1234);
        #1 check("lit_csri_csrr", csrr_addr_o, 32'h300);
        check("lit_csri_rs1", regr1_addr_o, 5'd0);
        tick();
        check("lit_csri_op1", op1_o, 32'd5);
        check("lit_csri_cwe", csrw_enable_o, 1'b1);
        check("lit_csri_cwd", csrw_data_o, 32'h1234);
        check("lit_csri_wa", regw_addr_o, 5'd7);

        // model-checked stream, held until the stage accepts each entry
        tbl[0]  = '{32'h00001317, 32'h200, 32'h0,    32'h0,  32'h0};
        tbl[1]  = '{32'h00C08067, 32'h204, 32'h1000, 32'h0,  32'h0};
        tbl[2]  = '{32'h0020A223, 32'h208, 32'h40,   32'h99, 32'h0};
        tbl[3]  = '{32'h300093F3, 32'h20C, 32'h55,   32'h0,  32'hABCD};
        tbl[4]  = '{32'h402081B3, 32'h210, 32'd10,   32'd3,  32'h0};
        tbl[5]  = '{32'h40209233, 32'h214, 32'd1,    32'd2,  32'h0};
        tbl[6]  = '{32'h00000073, 32'h218, 32'h0,    32'h0,  32'h0};
        tbl[7]  = '{32'h0000B283, 32'h21C, 32'h0,    32'h0,  32'h0};
        tbl[8]  = '{32'h0000A283, 32'h220, 32'h300,  32'h0,  32'h0};
        tbl[9]  = '{32'h00512023, 32'h224, 32'h80,   32'h77, 32'h0};
        tbl[10] = '{32'h00108393, 32'h228, 32'h11,   32'h0,  32'h0};
        tbl[11] = '{32'h4030D213, 32'h22C, 32'hF0,   32'h0,  32'h0};
        tbl[12] = '{32'h0020A463, 32'h230, 32'h1,    32'h2,  32'h0};
        for (int i = 0; i < 13; i++) begin
            present(1'b1, tbl[i].ins, tbl[i].pc, tbl[i].a, tbl[i].b, tbl[i].c);
            accepted = 1'b0;
            for (int w = 0; w < 4 && !accepted; w++) begin
                #1;
                accepted = m_ready;
                tick();
            end
            check("stream_accept", accepted, 1'b1);
        end

        // flush while a load-use hazard is pending
        present(1'b1, 32'h0000A283, 32'h300, 32'h400, 32'h0, 32'h0);
        tick();
        present(1'b1, 32'h00528333, 32'h304, 32'd2, 32'd2, 32'h0);
        ex_jump_flag_i = 1'b1;
        #1 check("lit_hflush_ready", id_ready_o, 1'b1);
        tick();
        check("lit_hflush_valid", id_valid_o, 1'b0);
        ex_jump_flag_i = 1'b0;
        tick();
        check("lit_hflush_add", regw_addr_o, 5'd6);

        // reset in the middle of a stall
        ex_ready_i = 1'b0;
        present(1'b1, 32'h00108393, 32'h308, 32'h1, 32'h0, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("lit_rst2_valid", id_valid_o, 1'b0);
        check("lit_rst2_inst", inst_o, 32'h0);
        check("lit_rst2_wa", regw_addr_o, 5'd0);
        rst = 1'b1;
        ex_ready_i = 1'b1;
        tick();
        tick();

        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
